uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial UART receiver. It is the consuming stage on the far end of the uart_tx serial line.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous rx line by oversampling at CLKS_PER_BIT clocks per bit.
- Presents each byte with a valid/ack handshake to the downstream host logic.
- Flags framing errors and overruns.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4
SYNC_STAGES, 2, flops in rx input synchronizer; >= 2

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted); all state cleared immediately on assertion
rx_in  input  1  asynchronous serial line, idle high
rx_ack  input  1  host acknowledges rx_data; clears rx_ready
rx_data  output  8  last good received byte, held until next good frame
rx_ready  output  1  level: unacknowledged byte in rx_data
rx_valid  output  1  one-cycle pulse when a good byte is loaded
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_overrun  output  1  one-cycle pulse: good byte loaded while rx_ready already high
rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: rx_data=8'h00, rx_ready=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0, state=IDLE. Synchronizer flops reset to 1 (line idle).
- Synchronizer: rx_in passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Counters:
  - clk_cnt: width clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - bit_idx: 3 bits.
- IDLE: the first cycle with rx_s=0 moves to START with clk_cnt=0.
- START: when clk_cnt==CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - rx_s=1: false start (glitch). Return to IDLE, no outputs.
  - rx_s=0: clk_cnt=0, bit_idx=0, go DATA.
- DATA: when clk_cnt==CLKS_PER_BIT-1, sample rx_s into shift register (shift right, sample enters bit 7) and set clk_cnt=0.
  - bit_idx 0..6: increment bit_idx.
  - bit_idx 7: go STOP.
- STOP: when clk_cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: in the same edge, rx_data<=shift, rx_valid<=1 for one cycle, rx_ready<=1. If rx_ready was already 1 and rx_ack is 0 that cycle, rx_overrun<=1 for one cycle (data is overwritten). Go IDLE.
  - rx_s=0: rx_frame_err<=1 for one cycle; rx_data/rx_ready unchanged; go BREAK.
- BREAK: wait for rx_s=1, then go IDLE. A held-low line (break) produces exactly one frame_err, not repeated frames.
- Handshake:
  - rx_ack=1 with rx_ready=1 clears rx_ready on the next edge.
  - rx_ack while rx_ready=0 is ignored.
  - Simultaneous rx_ack and a good-stop load: rx_ready stays 1 (the new byte wins), no overrun.
- Latency: rx_valid rises on the edge after the stop-bit mid-sample. That is SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+/-1) after the rx_in falling edge.
- The next frame's start bit is accepted from IDLE immediately after the stop sample. The block tolerates a transmitter running at 0.5 bit shorter stop.
- Reset asserted mid-frame: the frame is aborted; all outputs return to reset values asynchronously. After reset is released, the receiver waits in IDLE for the next falling edge. A line low at release is treated as a start.
- Illegal state encodings decode to IDLE.

Test Plan:
- CLKS_PER_BIT=16: send 8'hA5 as 8N1 → exactly one rx_valid pulse, rx_data=8'hA5, rx_ready=1, no err/overrun. rx_ack for one cycle → rx_ready=0 next cycle.
- Back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap, acking each → three rx_valid pulses, data in order, no errors.
- Two frames 8'h11 then 8'h22 without rx_ack → second load gives rx_overrun pulse, rx_data=8'h22, rx_ready=1.
- Frame 8'h55 with stop bit driven low, then line low for 40 bit times → one rx_frame_err pulse, rx_data unchanged, no rx_valid. After the line returns high, 8'h81 is received correctly.
- rx_in low pulse of CLKS_PER_BIT/4 cycles (glitch) → returns to IDLE, no pulses, rx_busy falls within CLKS_PER_BIT/2+SYNC_STAGES cycles.
- Reset asserted during data bit 4 of a frame → all outputs 0 immediately. After release, a full 8'hC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with input synchronizer, mid-bit sampling,
// valid/ack handshake to the host, and framing-error / overrun reporting.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;
  logic [CW-1:0]          r_clk_cnt;
  logic [CW-1:0]          w_clk_cnt_nxt;
  logic [2:0]             r_bit_idx;
  logic [2:0]             w_bit_idx_nxt;
  logic [7:0]             r_shift;
  logic [7:0]             w_shift_nxt;
  logic                   w_load;
  logic                   w_ferr;

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  // Synchronize the asynchronous line; flops preset to idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
    end
  end

  // State, bit timing counter, bit index and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state logic: start qualification, mid-bit sampling, stop check.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_load        = 1'b0;
    w_ferr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_clk_cnt == CNT_HALF) begin
          w_clk_cnt_nxt = '0;
          if (w_rx_s) begin
            // Line went back high before mid start bit: treat as a glitch.
            w_state_nxt = S_IDLE;
          end else begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = S_DATA;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == CNT_MAX) begin
          w_clk_cnt_nxt = '0;
          w_shift_nxt   = {w_rx_s, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == CNT_MAX) begin
          w_clk_cnt_nxt = '0;
          if (w_rx_s) begin
            w_load      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        // Hold here until the line idles so a break reports only once.
        w_clk_cnt_nxt = '0;
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_cnt_nxt = '0;
      end
    endcase
  end

  // Host-facing outputs: data hold, ready level, and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data      <= 8'h00;
      rx_ready     <= 1'b0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_valid     <= w_load;
      rx_frame_err <= w_ferr;
      // A simultaneous ack retires the old byte, so the new load is no overrun.
      rx_overrun   <= w_load & rx_ready & ~rx_ack;
      if (w_load) begin
        rx_data  <= r_shift;
        rx_ready <= 1'b1;
      end else if (rx_ack) begin
        rx_ready <= 1'b0;
      end
    end
  end

  // Busy in any legal non-idle state; illegal encodings read as idle.
  always_comb begin
    rx_busy = 1'b0;
    case (r_state)
      S_START, S_DATA, S_STOP, S_BREAK: rx_busy = 1'b1;
      default:                          rx_busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + randomized frames against a byte/event-level model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int SYNC    = 2;
  localparam int EXP_LAT = SYNC + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // Observed events, sampled on the falling edge.
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_ovr   = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid) begin
        n_valid++;
        got_q.push_back(rx_data);
      end
      if (rx_frame_err) n_ferr++;
      if (rx_overrun)   n_ovr++;
    end
  end

  // Reference model: what the host should see, frame by frame.
  int         exp_valid = 0;
  int         exp_ferr  = 0;
  int         exp_ovr   = 0;
  logic [7:0] exp_q[$];
  logic       m_ready = 1'b0;
  logic [7:0] m_data  = 8'h00;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_good(input logic [7:0] b);
    exp_valid++;
    exp_q.push_back(b);
    if (m_ready) exp_ovr++;
    m_ready = 1'b1;
    m_data  = b;
  endtask

  task automatic m_bad();
    exp_ferr++;
  endtask

  task automatic check_model(input string tag);
    int n;
    chk({tag, "_valid_cnt"}, 32'(n_valid), 32'(exp_valid));
    chk({tag, "_ferr_cnt"},  32'(n_ferr),  32'(exp_ferr));
    chk({tag, "_ovr_cnt"},   32'(n_ovr),   32'(exp_ovr));
    chk({tag, "_rx_ready"},  32'(rx_ready), 32'(m_ready));
    chk({tag, "_rx_data"},   32'(rx_data),  32'(m_data));
    chk({tag, "_q_len"},     32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    rx_in = stop;
    tick(CPB);
  endtask

  task automatic host_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    m_ready = 1'b0;
  endtask

  // Sends a burst of frames back to back while acknowledging every byte.
  task automatic burst_acked(input logic [7:0] bq[$]);
    fork
      begin
        foreach (bq[i]) send_frame(bq[i], 1'b1);
      end
      begin
        for (int c = 0; c < bq.size() * 10 * CPB; c++) begin
          rx_ack = rx_ready;
          tick(1);
        end
        rx_ack = 1'b0;
      end
    join
    foreach (bq[i]) begin
      m_good(bq[i]);
      m_ready = 1'b0;
    end
  endtask

  initial begin
    int         lat;
    int         cnt;
    logic [7:0] bq[$];
    logic [7:0] rb;

    reset  = 1'b0;
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    tick(3);
    chk("rst_rx_data",  32'(rx_data),      32'h0);
    chk("rst_rx_ready", 32'(rx_ready),     32'h0);
    chk("rst_rx_valid", 32'(rx_valid),     32'h0);
    chk("rst_ferr",     32'(rx_frame_err), 32'h0);
    chk("rst_ovr",      32'(rx_overrun),   32'h0);
    chk("rst_busy",     32'(rx_busy),      32'h0);
    reset = 1'b1;
    tick(5);

    // Single frame 0xA5 with latency measured from the start-bit edge.
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!rx_valid && lat < 400) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    chk("a5_latency_in_window",
        32'((lat >= EXP_LAT - 1) && (lat <= EXP_LAT + 1)), 32'h1);
    m_good(8'hA5);
    tick(2);
    check_model("a5");
    chk("a5_busy_idle", 32'(rx_busy), 32'h0);
    host_ack();
    chk("a5_ready_after_ack", 32'(rx_ready), 32'h0);

    // Back-to-back frames with no idle gap.
    bq = '{8'h00, 8'hFF, 8'h3C};
    burst_acked(bq);
    tick(2);
    check_model("b2b");

    // Randomized back-to-back burst.
    bq.delete();
    for (int i = 0; i < 5; i++) bq.push_back(8'($urandom));
    burst_acked(bq);
    tick(2);
    check_model("rand");

    // Two frames with no ack: second load overruns.
    send_frame(8'h11, 1'b1);
    m_good(8'h11);
    send_frame(8'h22, 1'b1);
    m_good(8'h22);
    tick(2);
    check_model("ovr");
    host_ack();
    chk("ovr_ready_after_ack", 32'(rx_ready), 32'h0);

    // Bad stop bit followed by a long break, then a clean frame.
    send_frame(8'h55, 1'b0);
    m_bad();
    tick(40 * CPB);
    chk("brk_busy_held", 32'(rx_busy), 32'h1);
    check_model("brk");
    rx_in = 1'b1;
    tick(2 * CPB);
    chk("brk_busy_released", 32'(rx_busy), 32'h0);
    send_frame(8'h81, 1'b1);
    m_good(8'h81);
    tick(2);
    check_model("post_brk");
    host_ack();

    // Short low glitch on an idle line.
    rx_in = 1'b0;
    tick(CPB / 4);
    rx_in = 1'b1;
    chk("glitch_busy_seen", 32'(rx_busy), 32'h1);
    cnt = 0;
    while (rx_busy && cnt < 4 * CPB) begin
      tick(1);
      cnt++;
    end
    chk("glitch_busy_fall_in_time", 32'(cnt <= CPB / 2 + SYNC), 32'h1);
    tick(CPB);
    check_model("glitch");

    // Reset in the middle of data bit 4, with an unacked byte pending.
    rb = 8'($urandom);
    send_frame(rb, 1'b1);
    m_good(rb);
    tick(2);
    check_model("pre_rst");
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_in = rb[i] ^ 1'b1;
      tick(CPB);
    end
    rx_in = 1'b1;
    tick(CPB / 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_rx_data",  32'(rx_data),      32'h0);
    chk("mid_rst_rx_ready", 32'(rx_ready),     32'h0);
    chk("mid_rst_rx_valid", 32'(rx_valid),     32'h0);
    chk("mid_rst_ferr",     32'(rx_frame_err), 32'h0);
    chk("mid_rst_ovr",      32'(rx_overrun),   32'h0);
    chk("mid_rst_busy",     32'(rx_busy),      32'h0);
    m_ready = 1'b0;
    m_data  = 8'h00;
    tick(3);
    reset = 1'b1;
    tick(2 * CPB);
    send_frame(8'hC3, 1'b1);
    m_good(8'hC3);
    tick(2);
    check_model("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
